// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fc_pkg
// Purpose : Shared defaults, data types and FSM state encoding for the
//           fully-connected classifier scheduler.
// Contents: VEC_W / RESULT_W / NUM_CLASSES defaults, score_t, vec_t,
//           fc_sched_state_e.
// Config  : none (FC_ALL_SCORES_EN is handled in fc_class_scheduler)
// Revision: 1.0 - initial release
// ============================================================================
package fc_pkg;

   localparam int VEC_W       = 64;
   localparam int RESULT_W    = 8;
   localparam int NUM_CLASSES = 4;

   typedef logic signed [RESULT_W-1:0] score_t;
   typedef logic [VEC_W-1:0]           vec_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fc_sched_state_e;

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_argmax_acc.sv
`default_nettype none
// ============================================================================
// Module  : fc_argmax_acc
// Purpose : Running signed maximum over a stream of (index, score) captures.
//           The first capture after a clear always loads; later captures
//           replace the held value only when strictly greater, so ties keep
//           the earliest (lowest) index.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           clear          - start a new search (drops the held maximum)
//           cap            - capture strobe for cap_idx / cap_score
//           max_idx        - index of the current maximum
//           max_score      - current maximum score (signed)
// Revision: 1.0 - initial release
// ============================================================================
module fc_argmax_acc #(
   parameter int RESULT_W = 8,
   parameter int IDX_W    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       cap,
   input  logic [IDX_W-1:0]           cap_idx,
   input  logic signed [RESULT_W-1:0] cap_score,
   output logic [IDX_W-1:0]           max_idx,
   output logic signed [RESULT_W-1:0] max_score
);
   import fc_pkg::*;

   logic have_max;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         have_max  <= 1'b0;
         max_idx   <= '0;
         max_score <= '0;
      end else if (cap && (!have_max || (cap_score > max_score))) begin
         have_max  <= 1'b1;
         max_idx   <= cap_idx;
         max_score <= cap_score;
      end
   end

endmodule : fc_argmax_acc
`default_nettype wire

// File: rtl/fc_class_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : fc_class_scheduler
// Purpose : Latches one pooled feature vector, drives it onto the shared FC
//           neuron, steps the neuron through every class weight set in the
//           local weight store, tracks the signed argmax of the returned
//           scores and presents class/score over a valid/ready handshake.
// Ports   : clk, rst                     - clock, sync active-high reset
//           in_valid/in_ready/in_pixels  - pooled vector input handshake
//           wgt_wr_en/addr/data          - weight store write port (IDLE only)
//           neuron_pixels/neuron_weight  - drive the FC neuron inputs
//           neuron_result                - neuron score, NEURON_LAT later
//           out_valid/out_ready          - classification handshake
//           out_class/out_score          - winning class and its score
//           out_scores                   - every class score (optional)
// Config  : `define FC_ALL_SCORES_EN adds the out_scores port.
// Revision: 1.0 - initial release
// ============================================================================
module fc_class_scheduler #(
   parameter  int NUM_CLASSES = fc_pkg::NUM_CLASSES,
   parameter  int VEC_W       = fc_pkg::VEC_W,
   parameter  int RESULT_W    = fc_pkg::RESULT_W,
   parameter  int NEURON_LAT  = 1,
   localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [VEC_W-1:0]           in_pixels,
   input  logic                       wgt_wr_en,
   input  logic [IDX_W-1:0]           wgt_wr_addr,
   input  logic [VEC_W-1:0]           wgt_wr_data,
   output logic [VEC_W-1:0]           neuron_pixels,
   output logic [VEC_W-1:0]           neuron_weight,
   input  logic [RESULT_W-1:0]        neuron_result,
`ifdef FC_ALL_SCORES_EN
   output logic [NUM_CLASSES-1:0][RESULT_W-1:0] out_scores,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [IDX_W-1:0]           out_class,
   output logic signed [RESULT_W-1:0] out_score
);
   import fc_pkg::*;

   fc_sched_state_e  state, state_n;
   logic [VEC_W-1:0] pix_q;
   logic [VEC_W-1:0] wmem [NUM_CLASSES];
   logic [IDX_W-1:0] iss_cnt;
   logic [IDX_W-1:0] cap_cnt;
   logic             issuing;
   logic             accept;
   logic             cap_vld;
   logic             last_issue;
   logic             last_cap;
   logic             addr_ok;

   assign issuing    = (state == ST_ISSUE);
   assign accept     = (state == ST_IDLE) && in_valid;
   assign last_issue = issuing && (iss_cnt == IDX_W'(NUM_CLASSES - 1));
   assign last_cap   = cap_vld && (cap_cnt == IDX_W'(NUM_CLASSES - 1));

   // ------------------------------------------------------------------
   // Controller
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = ST_ISSUE;
         end
         ST_ISSUE: begin
            // A zero-latency neuron has already delivered its last score
            // in the final issue cycle, so there is nothing to drain.
            if (last_issue) state_n = (NEURON_LAT == 0) ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (last_cap) state_n = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Weight store: writable only while idle so a run never scores
   // against a partially updated weight set.
   // ------------------------------------------------------------------
   generate
      if (NUM_CLASSES == (1 << IDX_W)) begin : g_addr_full
         assign addr_ok = 1'b1;
      end else begin : g_addr_part
         assign addr_ok = (wgt_wr_addr < IDX_W'(NUM_CLASSES));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CLASSES; k++) wmem[k] <= '0;
      end else if ((state == ST_IDLE) && wgt_wr_en && addr_ok) begin
         wmem[wgt_wr_addr] <= wgt_wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Vector latch and issue / capture counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_q   <= '0;
         iss_cnt <= '0;
         cap_cnt <= '0;
      end else if (accept) begin
         pix_q   <= in_pixels;
         iss_cnt <= '0;
         cap_cnt <= '0;
      end else begin
         if (issuing) iss_cnt <= iss_cnt + 1'b1;
         if (cap_vld) cap_cnt <= cap_cnt + 1'b1;
      end
   end

   // Capture strobe: the issue-valid bit delayed by the neuron latency
   // marks the cycle in which that class's score is on neuron_result.
   generate
      if (NEURON_LAT == 0) begin : g_lat_zero
         assign cap_vld = issuing;
      end else begin : g_lat_pipe
         logic [NEURON_LAT-1:0] iss_pipe;
         always_ff @(posedge clk) begin
            if (rst) iss_pipe <= '0;
            else     iss_pipe <= (iss_pipe << 1) | NEURON_LAT'(issuing);
         end
         assign cap_vld = iss_pipe[NEURON_LAT-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Argmax and outputs
   // ------------------------------------------------------------------
   fc_argmax_acc #(
      .RESULT_W (RESULT_W),
      .IDX_W    (IDX_W)
   ) u_argmax (
      .clk       (clk),
      .rst       (rst),
      .clear     (accept),
      .cap       (cap_vld),
      .cap_idx   (cap_cnt),
      .cap_score (neuron_result),
      .max_idx   (out_class),
      .max_score (out_score)
   );

`ifdef FC_ALL_SCORES_EN
   always_ff @(posedge clk) begin
      if (rst)          out_scores          <= '0;
      else if (cap_vld) out_scores[cap_cnt] <= neuron_result;
   end
`endif

   assign neuron_pixels = pix_q;
   assign neuron_weight = issuing ? wmem[iss_cnt] : wmem[0];

endmodule : fc_class_scheduler
`default_nettype wire

// File: tb/tb_fc_class_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fc_class_scheduler
// Purpose : Self-checking bench for fc_class_scheduler. Includes a byte-wise
//           dot-product neuron with one cycle of latency and a reference
//           model that scores every class and picks the signed argmax.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fc_class_scheduler;

   localparam int NC  = 4;
   localparam int VW  = 64;
   localparam int RW  = 8;
   localparam int IW  = 2;
   localparam int EXP_LAT = NC + 1 + 1;   // out_valid cycle after accept

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] in_pixels;
   logic          wgt_wr_en;
   logic [IW-1:0] wgt_wr_addr;
   logic [VW-1:0] wgt_wr_data;
   logic [VW-1:0] neuron_pixels;
   logic [VW-1:0] neuron_weight;
   logic [RW-1:0] neuron_result;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_class;
   logic signed [RW-1:0] out_score;
`ifdef FC_ALL_SCORES_EN
   logic [NC-1:0][RW-1:0] out_scores;
`endif

   int errors = 0;
   int checks = 0;

   logic [VW-1:0] mw [NC];   // model of the weight store

   always #5 clk = ~clk;

   fc_class_scheduler #(
      .NUM_CLASSES (NC),
      .VEC_W       (VW),
      .RESULT_W    (RW),
      .NEURON_LAT  (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pixels     (in_pixels),
      .wgt_wr_en     (wgt_wr_en),
      .wgt_wr_addr   (wgt_wr_addr),
      .wgt_wr_data   (wgt_wr_data),
      .neuron_pixels (neuron_pixels),
      .neuron_weight (neuron_weight),
      .neuron_result (neuron_result),
`ifdef FC_ALL_SCORES_EN
      .out_scores    (out_scores),
`endif
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_class     (out_class),
      .out_score     (out_score)
   );

   // Sum of signed byte products, truncated to 8 bits.
   function automatic logic [RW-1:0] dot8(input logic [VW-1:0] p, input logic [VW-1:0] w);
      int acc;
      acc = 0;
      for (int i = 0; i < 8; i++)
         acc += int'($signed(p[8*i +: 8])) * int'($signed(w[8*i +: 8]));
      return acc[RW-1:0];
   endfunction

   always_ff @(posedge clk) neuron_result <= dot8(neuron_pixels, neuron_weight);

   // Reference: score every class, take the first strictly largest.
   function automatic void ref_argmax(input logic [VW-1:0] pix, output int cls,
                                      output logic signed [RW-1:0] sc);
      logic signed [RW-1:0] s;
      cls = 0;
      sc  = $signed(dot8(pix, mw[0]));
      for (int k = 1; k < NC; k++) begin
         s = $signed(dot8(pix, mw[k]));
         if (s > sc) begin
            sc  = s;
            cls = k;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_w(input int addr, input logic [VW-1:0] data);
      wgt_wr_en   = 1'b1;
      wgt_wr_addr = IW'(addr);
      wgt_wr_data = data;
      tick();
      wgt_wr_en   = 1'b0;
      mw[addr]    = data;
   endtask

   // Offer a vector (optionally with a same-cycle weight write) and wait for
   // out_valid. lat is the cycle index in which out_valid was first seen.
   task automatic send_vec(input logic [VW-1:0] pix, input bit we, input int waddr,
                           input logic [VW-1:0] wdata, output int lat, output bit got);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         tick();
         w++;
      end
      in_valid  = 1'b1;
      in_pixels = pix;
      if (we) begin
         wgt_wr_en   = 1'b1;
         wgt_wr_addr = IW'(waddr);
         wgt_wr_data = wdata;
         mw[waddr]   = wdata;
      end
      tick();
      in_valid  = 1'b0;
      wgt_wr_en = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      got = out_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < NC; k++) mw[k] = '0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_class !== '0) begin errors++; $display("FAIL reset_out_class got=%0d exp=0", out_class); end
      checks++; if (out_score !== '0) begin errors++; $display("FAIL reset_out_score got=%0d exp=0", out_score); end
      checks++; if (neuron_pixels !== '0) begin errors++; $display("FAIL reset_pixels got=%h exp=0", neuron_pixels); end
      checks++; if (neuron_weight !== '0) begin errors++; $display("FAIL reset_weight got=%h exp=0", neuron_weight); end
   endtask

   task automatic test_directed();
      int lat; bit got;
      write_w(0, 64'h01ffff01_ff0101ff);
      write_w(1, 64'hff0101ff_01ffff01);
      write_w(2, 64'hffffffff_ff0101ff);
      write_w(3, 64'h01ffff01_ffffffff);
      checks++; if (neuron_weight !== 64'h01ffff01_ff0101ff) begin errors++; $display("FAIL idle_weight got=%h exp=01ffff01ff0101ff", neuron_weight); end
      send_vec(64'h01ffff01_ff0101ff, 1'b0, 0, '0, lat, got);
      checks++; if (lat !== EXP_LAT || !got) begin errors++; $display("FAIL dir0_latency got=%0d valid=%b exp=%0d", lat, got, EXP_LAT); end
      checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL dir0_class got=%0d exp=0", out_class); end
      checks++; if (out_score !== 8'sd8) begin errors++; $display("FAIL dir0_score got=%0d exp=8", out_score); end
`ifdef FC_ALL_SCORES_EN
      checks++; if (out_scores !== {8'h04, 8'h04, 8'hf8, 8'h08}) begin errors++; $display("FAIL dir0_all_scores got=%h exp=0404f808", out_scores); end
`endif
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL dir0_handoff valid=%b ready=%b exp=0/1", out_valid, in_ready); end
      send_vec(64'hff0101ff_01ffff01, 1'b0, 0, '0, lat, got);
      checks++; if (out_class !== 2'd1) begin errors++; $display("FAIL dir1_class got=%0d exp=1", out_class); end
      checks++; if (out_score !== 8'sd8) begin errors++; $display("FAIL dir1_score got=%0d exp=8", out_score); end
      checks++; if (neuron_pixels !== 64'hff0101ff_01ffff01) begin errors++; $display("FAIL dir1_pixels got=%h exp=ff0101ff01ffff01", neuron_pixels); end
      tick();
   endtask

   task automatic test_tie();
      int lat; bit got;
      write_w(0, '0);
      write_w(1, '0);
      send_vec(64'h01ffff01_ff0101ff, 1'b0, 0, '0, lat, got);
      checks++; if (out_class !== 2'd2) begin errors++; $display("FAIL tie_class got=%0d exp=2", out_class); end
      checks++; if (out_score !== 8'sd4) begin errors++; $display("FAIL tie_score got=%0d exp=4", out_score); end
      tick();
   endtask

   task automatic test_stall();
      int lat; bit got;
      write_w(0, 64'h01ffff01_ff0101ff);
      write_w(1, 64'hff0101ff_01ffff01);
      out_ready = 1'b0;
      send_vec(64'h01ffff01_ff0101ff, 1'b0, 0, '0, lat, got);
      checks++; if (!got) begin errors++; $display("FAIL stall_valid_timeout got=%b exp=1", got); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL stall_class[%0d] got=%0d exp=0", i, out_class); end
         checks++; if (out_score !== 8'sd8) begin errors++; $display("FAIL stall_score[%0d] got=%0d exp=8", i, out_score); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
         if (i == 3) begin
            // Would zero class 0 if it landed; the model keeps the old weight.
            wgt_wr_en = 1'b1; wgt_wr_addr = 2'd0; wgt_wr_data = '0;
         end
         tick();
         wgt_wr_en = 1'b0;
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release valid=%b ready=%b exp=0/1", out_valid, in_ready); end
      send_vec(64'h01ffff01_ff0101ff, 1'b0, 0, '0, lat, got);
      checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL stall_drop_class got=%0d exp=0", out_class); end
      checks++; if (out_score !== 8'sd8) begin errors++; $display("FAIL stall_drop_score got=%0d exp=8", out_score); end
      tick();
   endtask

   task automatic test_reset_midrun();
      int lat; bit got; bit seen;
      in_valid  = 1'b1;
      in_pixels = 64'h01ffff01_ff0101ff;
      tick();                       // now in cycle 1
      in_valid = 1'b0;
      tick();                       // cycle 2
      tick();                       // cycle 3
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < NC; k++) mw[k] = '0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output got=%b exp=0", seen); end
      send_vec({$urandom, $urandom}, 1'b0, 0, '0, lat, got);
      checks++; if (!got || out_class !== 2'd0) begin errors++; $display("FAIL midrst_class got=%0d valid=%b exp=0", out_class, got); end
      checks++; if (out_score !== 8'sd0) begin errors++; $display("FAIL midrst_score got=%0d exp=0", out_score); end
      tick();
   endtask

   task automatic test_random();
      int lat; bit got; int ecls; logic signed [RW-1:0] esc;
      logic [VW-1:0] pix; bit we; int wa; logic [VW-1:0] wd; int d;
      for (int n = 0; n < NC; n++) write_w(n, {$urandom, $urandom});
      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 1) == 1) write_w($urandom_range(0, NC-1), {$urandom, $urandom});
         pix = {$urandom, $urandom};
         we  = ($urandom_range(0, 1) == 1);
         wa  = $urandom_range(0, NC-1);
         wd  = {$urandom, $urandom};
         d   = $urandom_range(0, 3);
         out_ready = (d == 0);
         send_vec(pix, we, wa, wd, lat, got);   // model weight updated first
         ref_argmax(pix, ecls, esc);
         checks++; if (lat !== EXP_LAT || !got) begin errors++; $display("FAIL rnd%0d_latency got=%0d valid=%b exp=%0d", it, lat, got, EXP_LAT); end
         checks++; if (out_class !== IW'(ecls)) begin errors++; $display("FAIL rnd%0d_class got=%0d exp=%0d", it, out_class, ecls); end
         checks++; if (out_score !== esc) begin errors++; $display("FAIL rnd%0d_score got=%0d exp=%0d", it, out_score, esc); end
         for (int i = 0; i < d; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_class !== IW'(ecls)) begin errors++; $display("FAIL rnd%0d_hold valid=%b class=%0d exp=1/%0d", it, out_valid, out_class, ecls); end
         end
         out_ready = 1'b1;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int acc_cyc[$];
      int w;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pixels = {$urandom, $urandom};
      for (int c = 0; c < 30; c++) begin
         if (in_ready) acc_cyc.push_back(c);
         tick();
      end
      in_valid = 1'b0;
      checks++; if (acc_cyc.size() < 4) begin errors++; $display("FAIL b2b_accepts got=%0d exp>=4", acc_cyc.size()); end
      for (int i = 1; i < acc_cyc.size() && i < 4; i++) begin
         checks++; if (acc_cyc[i] - acc_cyc[i-1] !== NC + 1 + 2) begin errors++; $display("FAIL b2b_interval%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1], NC + 3); end
      end
      w = 0;
      while (!in_ready && w < 40) begin
         tick();
         w++;
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain got=%b exp=1", in_ready); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_pixels = '0; wgt_wr_en = 1'b0;
      wgt_wr_addr = '0; wgt_wr_data = '0; out_ready = 1'b1;
      test_reset();
      test_directed();
      test_tie();
      test_stall();
      test_reset_midrun();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fc_class_scheduler
`default_nettype wire

// File: doc/fc_class_scheduler.md
# fc_class_scheduler

Sequencer for the fully-connected classifier stage. Accepts one pooled feature vector, holds it on the FC neuron input, and steps the neuron through every class weight set held in a local weight store. It collects each class score and reports the signed argmax class with its score over a valid/ready handshake. Sits between the pooling stage and the classification output, and owns the single shared `FC_neuron` instance's weight and pixel inputs.

## Interface
- `NUM_CLASSES`, 4: number of weight sets and scores per input; ≥2.
- `VEC_W`, 64: pixel and weight vector width; 8 signed bytes.
- `RESULT_W`, 8: neuron score width; signed two's complement.
- `NEURON_LAT`, 1: cycles from neuron inputs changing to `neuron_result` valid; ≥0.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: pooled vector offered.
- `in_ready` out 1: scheduler can accept a vector.
- `in_pixels` in VEC_W: [63:32] = kernel-0 pooled map, [31:0] = kernel-1 pooled map.
- `wgt_wr_en` in 1: weight-store write strobe.
- `wgt_wr_addr` in clog2(NUM_CLASSES): class index to write.
- `wgt_wr_data` in VEC_W: weight vector for that class.
- `neuron_pixels` out VEC_W: to neuron `pooledPixelArray`.
- `neuron_weight` out VEC_W: to neuron `weight`.
- `neuron_result` in RESULT_W: neuron score.
- `out_valid` out 1: classification available.
- `out_ready` in 1: consumer accepts the classification.
- `out_class` out clog2(NUM_CLASSES): winning class index.
- `out_score` out RESULT_W: winning score, signed.

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch `in_pixels` into `pix_q`, clear `iss_cnt` and `cap_cnt`, and go to ISSUE.
- ISSUE:
  - `neuron_weight` = `wmem[iss_cnt]`; `iss_cnt` increments each cycle.
  - After issuing index `NUM_CLASSES-1`, go to DRAIN.
- DRAIN:
  - Waits until all `NUM_CLASSES` results have been captured, then goes to DONE.
  - With `NEURON_LAT`=0, capture is in the same cycle as issue, and DRAIN lasts 0 cycles (ISSUE goes directly to DONE).
- Capture (runs in ISSUE and DRAIN): the result for issue cycle t is sampled at the edge ending cycle t+`NEURON_LAT`, using a delayed issue-valid shift register.
- Argmax:
  - The first capture loads `max_score` and `max_idx`.
  - Later captures replace them only if the new score is strictly greater (signed compare).
  - Ties go to the lowest index.
- DONE:
  - `out_valid`=1; `out_class`/`out_score` are held stable until `out_valid && out_ready`, then the FSM returns to IDLE.
- `neuron_pixels` = `pix_q` at all times.
- `neuron_weight` = `wmem[0]` outside ISSUE.
- Weight writes:
  - Applied only in IDLE.
  - Writes in other states are dropped silently, so scoring never sees a mixed weight set.
  - A write and an accept in the same IDLE cycle: the write lands first and is used by that run.
- `wgt_wr_addr` ≥ `NUM_CLASSES`: write ignored.
- `in_valid` while not IDLE: ignored (`in_ready`=0); the upstream stage holds its data.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0, `out_class`=0, `out_score`=0.
  - `pix_q`=0, all `wmem` entries=0, counters=0.
- `rst` asserted mid-run: the run is aborted at the next edge and no output is produced; weights are cleared.
- Latency: accept edge ends cycle 0; `out_valid` rises in cycle `NUM_CLASSES+NEURON_LAT+1` (defaults: cycle 6).
- Throughput: one vector per `NUM_CLASSES+NEURON_LAT+2` cycles when `out_ready` is held high. No accept occurs in the DONE→IDLE handoff cycle.

## Configuration
- `FC_ALL_SCORES_EN`:
  - Defined: adds output `out_scores` [NUM_CLASSES][RESULT_W], holding every captured score (index k = class k), valid with `out_valid`, reset to 0.
  - Undefined: no score array, no port; only the running max is stored.

## Structure
- Package `fc_pkg`:
  - `VEC_W`, `RESULT_W`, `NUM_CLASSES` defaults.
  - `typedef logic signed [RESULT_W-1:0] score_t`.
  - `typedef logic [VEC_W-1:0] vec_t`.
  - FSM state enum `fc_sched_state_e`.
- One sub-module, `fc_argmax_acc`: running signed max with lowest-index tie-break, a clear input and a capture strobe.
- The weight store is a flat register array in the top module.

## Test plan
- Bench neuron model: sum of signed byte products, truncated to 8 bits, `NEURON_LAT`=1.
- Load weights class0 = 01ffff01_ff0101ff, class1 = ff0101ff_01ffff01, class2 = ffffffff_ff0101ff, class3 = 01ffff01_ffffffff.
  - Input 01ffff01_ff0101ff -> class 0, score 8; cycle 6 `out_valid`.
- Same weights, input ff0101ff_01ffff01 -> class 1, score 8.
- Tie: zero class0/class1 weights, input 01ffff01_ff0101ff -> scores 0,0,4,4 -> class 2, score 4.
- `out_ready` held low 10 cycles:
  - `out_valid`/class/score stay stable; `in_ready`=0 throughout.
  - A weight write issued during the stall is dropped (readback through the next run unchanged).
- `rst` pulsed in cycle 3 of a run -> no `out_valid`, `in_ready`=1 next cycle, all scores from the next run are 0 (weights cleared).
- With `FC_ALL_SCORES_EN`, first scenario -> `out_scores` = {8, -8 (f8), 4, 4}.
